// File: rtl/seven_seg_pkg.sv
// Shared 7-segment encoding: active-high patterns with segment A at bit 6, G at bit 0.
// The display encoder uses the same table.
package seven_seg_pkg;

    localparam int SEG_IDX_A = 6;
    localparam int SEG_IDX_B = 5;
    localparam int SEG_IDX_C = 4;
    localparam int SEG_IDX_D = 3;
    localparam int SEG_IDX_E = 2;
    localparam int SEG_IDX_F = 1;
    localparam int SEG_IDX_G = 0;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational inverse of the segment table: active-high pattern to hex digit,
// with flags for legal digits and the all-off pattern.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] hex,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        hex   = 4'h0;
        legal = 1'b1;
        blank = 1'b0;
        case (pattern)
            SEG_0:     hex = 4'h0;
            SEG_1:     hex = 4'h1;
            SEG_2:     hex = 4'h2;
            SEG_3:     hex = 4'h3;
            SEG_4:     hex = 4'h4;
            SEG_5:     hex = 4'h5;
            SEG_6:     hex = 4'h6;
            SEG_7:     hex = 4'h7;
            SEG_8:     hex = 4'h8;
            SEG_9:     hex = 4'h9;
            SEG_A:     hex = 4'hA;
            SEG_B:     hex = 4'hB;
            SEG_C:     hex = 4'hC;
            SEG_D:     hex = 4'hD;
            SEG_E:     hex = 4'hE;
            SEG_F:     hex = 4'hF;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Segment-line receiver: synchronizes the pins, waits for a stable pattern,
// then decodes it and reports legal, blank and illegal acceptances.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Segment_A,
    input  logic       i_Segment_B,
    input  logic       i_Segment_C,
    input  logic       i_Segment_D,
    input  logic       i_Segment_E,
    input  logic       i_Segment_F,
    input  logic       i_Segment_G,
    output logic [3:0] o_Hex,
    output logic       o_Hex_Valid,
    output logic       o_Blank,
    output logic       o_Valid,
    output logic       o_Invalid,
    output logic [7:0] o_Error_Count
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0]       UNLIT   = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0]       seg_raw;
    logic [6:0]       p;
    logic             accept;
    logic [3:0]       dec_hex;
    logic             dec_legal;
    logic             dec_blank;

    logic [6:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [6:0]       p_prev_q, p_prev_d, acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       hex_q, hex_d;
    logic             hex_valid_q, hex_valid_d, blank_q, blank_d;
    logic             valid_q, valid_d, invalid_q, invalid_d;
    logic [7:0]       err_q, err_d;

    always_comb begin
        seg_raw            = '0;
        seg_raw[SEG_IDX_A] = i_Segment_A;
        seg_raw[SEG_IDX_B] = i_Segment_B;
        seg_raw[SEG_IDX_C] = i_Segment_C;
        seg_raw[SEG_IDX_D] = i_Segment_D;
        seg_raw[SEG_IDX_E] = i_Segment_E;
        seg_raw[SEG_IDX_F] = i_Segment_F;
        seg_raw[SEG_IDX_G] = i_Segment_G;
    end

    assign p = ACTIVE_LOW ? ~sync2_q : sync2_q;

    seven_seg_decode u_decode (
        .pattern (p),
        .hex     (dec_hex),
        .legal   (dec_legal),
        .blank   (dec_blank)
    );

    // Re-presenting the already accepted pattern is never an event.
    assign accept = (cnt_q == CNT_MAX) && (p == p_prev_q) && (p != acc_q);

    always_comb begin
        sync1_d     = seg_raw;
        sync2_d     = sync1_q;
        p_prev_d    = p;
        acc_d       = acc_q;
        hex_d       = hex_q;
        hex_valid_d = hex_valid_q;
        blank_d     = blank_q;
        valid_d     = 1'b0;
        invalid_d   = 1'b0;
        err_d       = err_q;

        if (p != p_prev_q)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

        if (accept) begin
            acc_d = p;
            if (dec_legal) begin
                hex_d       = dec_hex;
                hex_valid_d = 1'b1;
                blank_d     = 1'b0;
                valid_d     = 1'b1;
            end else if (dec_blank) begin
                hex_valid_d = 1'b0;
                blank_d     = 1'b1;
            end else begin
                hex_valid_d = 1'b0;
                blank_d     = 1'b0;
                invalid_d   = 1'b1;
                if (err_q != 8'hFF)
                    err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q     <= UNLIT;
            sync2_q     <= UNLIT;
            p_prev_q    <= SEG_BLANK;
            acc_q       <= SEG_BLANK;
            cnt_q       <= '0;
            hex_q       <= 4'h0;
            hex_valid_q <= 1'b0;
            blank_q     <= 1'b1;
            valid_q     <= 1'b0;
            invalid_q   <= 1'b0;
            err_q       <= 8'h00;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            p_prev_q    <= p_prev_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            hex_q       <= hex_d;
            hex_valid_q <= hex_valid_d;
            blank_q     <= blank_d;
            valid_q     <= valid_d;
            invalid_q   <= invalid_d;
            err_q       <= err_d;
        end
    end

    assign o_Hex         = hex_q;
    assign o_Hex_Valid   = hex_valid_q;
    assign o_Blank       = blank_q;
    assign o_Valid       = valid_q;
    assign o_Invalid     = invalid_q;
    assign o_Error_Count = err_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader: active-low instance for most scenarios,
// plus an active-high instance for the polarity check.
module tb_seven_seg_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] pins0 = 7'h7F;
    logic [6:0] pins1 = 7'h00;

    logic [3:0] hex0, hex1;
    logic       hv0, hv1, blank0, blank1, v0, v1, inv0, inv1;
    logic [7:0] err0, err1;

    int tests = 0;
    int fails = 0;
    int both  = 0;

    always #5 clk = ~clk;

    seven_seg_reader #(.STABLE_CYCLES(16), .ACTIVE_LOW(1'b1)) dut0 (
        .i_Clk(clk), .i_Reset(rst),
        .i_Segment_A(pins0[6]), .i_Segment_B(pins0[5]), .i_Segment_C(pins0[4]),
        .i_Segment_D(pins0[3]), .i_Segment_E(pins0[2]), .i_Segment_F(pins0[1]),
        .i_Segment_G(pins0[0]),
        .o_Hex(hex0), .o_Hex_Valid(hv0), .o_Blank(blank0), .o_Valid(v0),
        .o_Invalid(inv0), .o_Error_Count(err0)
    );

    seven_seg_reader #(.STABLE_CYCLES(16), .ACTIVE_LOW(1'b0)) dut1 (
        .i_Clk(clk), .i_Reset(rst),
        .i_Segment_A(pins1[6]), .i_Segment_B(pins1[5]), .i_Segment_C(pins1[4]),
        .i_Segment_D(pins1[3]), .i_Segment_E(pins1[2]), .i_Segment_F(pins1[1]),
        .i_Segment_G(pins1[0]),
        .o_Hex(hex1), .o_Hex_Valid(hv1), .o_Blank(blank1), .o_Valid(v1),
        .o_Invalid(inv1), .o_Error_Count(err1)
    );

    typedef struct {
        logic [6:0] pat;
        logic [3:0] hex;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive an active-high pattern onto dut0 (active-low pins) at a negedge and
    // observe 'cycles' subsequent edges; edge i is sampled at the i-th negedge.
    task automatic apply(input logic [6:0] hi, input int cycles,
                         output int nv, output int ninv, output int first_v,
                         output logic [3:0] last_hex);
        nv = 0; ninv = 0; first_v = 0; last_hex = hex0;
        pins0 = ~hi;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            if (v0 && inv0) both++;
            if (v0) begin
                nv++;
                if (first_v == 0) first_v = i;
                last_hex = hex0;
            end
            if (inv0) ninv++;
        end
    endtask

    initial begin
        int nv, ninv, fv, tot_inv, blank_miss, hv_miss;
        logic [3:0] lh;

        vecs[0]  = '{7'h7E, 4'h0}; vecs[1]  = '{7'h30, 4'h1};
        vecs[2]  = '{7'h6D, 4'h2}; vecs[3]  = '{7'h79, 4'h3};
        vecs[4]  = '{7'h33, 4'h4}; vecs[5]  = '{7'h5B, 4'h5};
        vecs[6]  = '{7'h5F, 4'h6}; vecs[7]  = '{7'h70, 4'h7};
        vecs[8]  = '{7'h7F, 4'h8}; vecs[9]  = '{7'h7B, 4'h9};
        vecs[10] = '{7'h77, 4'hA}; vecs[11] = '{7'h1F, 4'hB};
        vecs[12] = '{7'h4E, 4'hC}; vecs[13] = '{7'h3D, 4'hD};
        vecs[14] = '{7'h4F, 4'hE}; vecs[15] = '{7'h47, 4'hF};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_hex", {28'd0, hex0}, 32'h0);
        check("rst_hex_valid", {31'd0, hv0}, 32'h0);
        check("rst_blank", {31'd0, blank0}, 32'h1);
        check("rst_valid", {31'd0, v0}, 32'h0);
        check("rst_invalid", {31'd0, inv0}, 32'h0);
        check("rst_err", {24'd0, err0}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: steady "5"
        apply(7'h5B, 25, nv, ninv, fv, lh);
        check("s1_nvalid", nv, 1);
        check("s1_latency", fv, 19);
        check("s1_hex", {28'd0, hex0}, 32'h5);
        check("s1_hex_valid", {31'd0, hv0}, 32'h1);
        check("s1_blank", {31'd0, blank0}, 32'h0);

        // 2: short excursion to "8" then back to accepted "5"
        apply(7'h7F, 10, nv, ninv, fv, lh);
        check("s2_glitch_pulses", nv + ninv, 0);
        apply(7'h5B, 30, nv, ninv, fv, lh);
        check("s2_return_pulses", nv + ninv, 0);
        check("s2_hex", {28'd0, hex0}, 32'h5);

        // 3: every legal digit
        for (int k = 0; k < 16; k++) begin
            apply(vecs[k].pat, 20, nv, ninv, fv, lh);
            check($sformatf("s3_nvalid_%0d", k), nv, 1);
            check($sformatf("s3_hex_%0d", k), {28'd0, lh}, {28'd0, vecs[k].hex});
        end
        check("s3_hex_valid", {31'd0, hv0}, 32'h1);
        check("s3_err", {24'd0, err0}, 32'h0);

        // 4: illegal / blank alternation, error counter saturation
        tot_inv = 0; blank_miss = 0; hv_miss = 0;
        for (int k = 0; k < 300; k++) begin
            apply(7'h01, 20, nv, ninv, fv, lh);
            tot_inv += ninv;
            if (hv0 !== 1'b0 || blank0 !== 1'b0) hv_miss++;
            if (k == 253) check("s4_err_254", {24'd0, err0}, 32'd254);
            if (k == 254) check("s4_err_255", {24'd0, err0}, 32'd255);
            apply(7'h00, 20, nv, ninv, fv, lh);
            tot_inv += ninv;
            if (nv != 0) hv_miss++;
            if (blank0 !== 1'b1 || hv0 !== 1'b0) blank_miss++;
        end
        check("s4_invalid_pulses", tot_inv, 300);
        check("s4_err_sat", {24'd0, err0}, 32'hFF);
        check("s4_illegal_flags", hv_miss, 0);
        check("s4_blank_flags", blank_miss, 0);
        check("s4_hex_hold", {28'd0, hex0}, 32'hF);

        // 5: reset in the middle of a qualification window
        apply(7'h79, 12, nv, ninv, fv, lh);
        check("s5_pre_reset_pulses", nv, 0);
        rst = 1'b1;
        @(negedge clk);
        check("s5_rst_hex", {28'd0, hex0}, 32'h0);
        check("s5_rst_blank", {31'd0, blank0}, 32'h1);
        check("s5_rst_err", {24'd0, err0}, 32'h0);
        rst = 1'b0;
        apply(7'h79, 25, nv, ninv, fv, lh);
        check("s5_nvalid", nv, 1);
        check("s5_latency", fv, 19);
        check("s5_hex", {28'd0, hex0}, 32'h3);

        // 6: active-high instance
        pins1 = 7'h47;
        fv = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (v1 && fv == 0) fv = i;
        end
        check("s6_latency", fv, 19);
        check("s6_hex", {28'd0, hex1}, 32'hF);
        check("s6_hex_valid", {31'd0, hv1}, 32'h1);

        check("valid_invalid_overlap", both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
